sw_feeder: RTL and testbench

Board-side transmitter for the picoMIPS switch-input handshake. The CPU program polls `SW8` high, reads `uInput`, then polls `SW8` low before the next input. This block is the sending end of that protocol. It buffers bytes from a host/testbench port in a small FIFO and presents each one on `uinput` with a timed `sw8` pulse. It optionally captures the CPU's `outport` after each transfer. It sits beside `cpu` in the board top level and replaces the manual switches for automated runs.

---
 rtl/sw_feeder_pkg.sv | 17 +
 rtl/feeder_fifo.sv | 48 ++++
 rtl/sw_feeder.sv | 100 ++++++++++
 tb/tb_sw_feeder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sw_feeder_pkg.sv
// Shared types and helpers for the sw_feeder switch-handshake transmitter.
package sw_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } feeder_state_t;

  // Counter width that holds max(hold, gap)-1; never narrower than one bit.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Flop-based FIFO for sw_feeder: synchronous write/pop, wrap-bit pointers.
module feeder_fifo #(
  parameter int n     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         wr_en,
  input  logic [n-1:0] wr_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [n-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [n-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_ok;
  logic         pop_ok;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head   = mem[rd_ptr[AW-1:0]];
  // A write while full is dropped even if the same edge pops.
  assign wr_ok  = wr_en && !full;
  assign pop_ok = pop && !empty;

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sw_feeder.sv
// Sends queued bytes to the CPU with timed SW8 pulses; optional outport capture
// is built only when SW_FEEDER_CAPTURE_EN is defined.
module sw_feeder
  import sw_feeder_pkg::*;
#(
  parameter int n     = 8,
  parameter int DEPTH = 4,
  parameter int HOLD  = 16,
  parameter int GAP   = 16
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         wr_en,
  input  logic [n-1:0] wr_data,
  output logic         full,
  output logic         empty,
  output logic         busy,
  output logic         sw8,
  output logic [n-1:0] uinput,
  input  logic [n-1:0] outport_in,
  output logic [n-1:0] result,
  output logic         result_valid
);

  localparam int CW = cnt_width(HOLD, GAP);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  feeder_state_t state;
  logic [CW-1:0] cnt;
  logic [n-1:0]  head;
  logic          pop;
  logic          gap_done;

  feeder_fifo #(.n(n), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign gap_done = (state == RELEASE) && (cnt == '0);
  // The end of a gap pops straight into PRESENT so back-to-back bytes skip IDLE.
  assign pop      = !empty && ((state == IDLE) || gap_done);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      cnt    <= '0;
      sw8    <= 1'b0;
      uinput <= '0;
    end else if (pop) begin
      uinput <= head;
      sw8    <= 1'b1;
      cnt    <= HOLD_LD;
      state  <= PRESENT;
    end else begin
      case (state)
        PRESENT: begin
          if (cnt == '0) begin
            sw8   <= 1'b0;
            cnt   <= GAP_LD;
            state <= RELEASE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        RELEASE: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SW_FEEDER_CAPTURE_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= gap_done;
      if (gap_done) result <= outport_in;
    end
  end
`else
  logic unused_outport;
  assign unused_outport = ^outport_in;
  assign result         = '0;
  assign result_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_sw_feeder.sv
// Directed bench for sw_feeder (HOLD=16, GAP=16, DEPTH=4); expectations follow
// the SW_FEEDER_CAPTURE_EN setting of the build.
module tb_sw_feeder;

`ifdef SW_FEEDER_CAPTURE_EN
  localparam logic CAP = 1'b1;
`else
  localparam logic CAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] outport_in = 8'h00;
  logic       full, empty, busy, sw8, result_valid;
  logic [7:0] uinput, result;

  int n_checks = 0;
  int n_fail   = 0;
  int rv_count = 0;

  sw_feeder #(.n(8), .DEPTH(4), .HOLD(16), .GAP(16)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .busy         (busy),
    .sw8          (sw8),
    .uinput       (uinput),
    .outport_in   (outport_in),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (result_valid === 1'b1) rv_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int hi, lo, rv_before;
    logic uinput_bad, seen_sw8;
    logic [7:0] seq [5];
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03; seq[3] = 8'h04; seq[4] = 8'h07;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sw8", sw8, 0);
    check("rst_uinput", uinput, 8'h00);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 8'h00);
    check("rst_result_valid", result_valid, 0);
    nreset = 1'b1;
    @(negedge clk);

    // Single byte
    outport_in = 8'hA5;
    wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0;
    check("single_empty_fall", empty, 0);
    check("single_sw8_not_yet", sw8, 0);
    @(negedge clk);
    check("single_sw8_rise", sw8, 1);
    check("single_uinput", uinput, 8'h5A);
    check("single_busy", busy, 1);
    hi = 0; uinput_bad = 1'b0;
    while (sw8 === 1'b1 && hi < 100) begin
      if (uinput !== 8'h5A) uinput_bad = 1'b1;
      hi++;
      @(negedge clk);
    end
    check("single_hold_cycles", hi, 16);
    check("single_uinput_stable", uinput_bad, 0);
    lo = 0;
    while (sw8 === 1'b0 && busy === 1'b1 && lo < 100) begin
      if (uinput !== 8'h5A) uinput_bad = 1'b1;
      lo++;
      @(negedge clk);
    end
    check("single_gap_cycles", lo, 16);
    check("single_uinput_gap_stable", uinput_bad, 0);
    check("single_idle", busy, 0);
    check("single_result", result, CAP ? 32'hA5 : 32'h0);
    check("single_result_valid", result_valid, CAP);
    @(negedge clk);
    check("single_result_valid_pulse", result_valid, 0);
    check("single_uinput_hold_idle", uinput, 8'h5A);

    // Burst behind a primer byte, then a write on the pop edge while full
    outport_in = 8'h3C;
    wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk); wr_data = 8'h01;
    @(negedge clk); wr_data = 8'h02;
    check("burst_primer_uinput", uinput, 8'hEE);
    check("burst_primer_sw8", sw8, 1);
    @(negedge clk); wr_data = 8'h03;
    @(negedge clk); wr_data = 8'h04;
    check("burst_not_full_3", full, 0);
    @(negedge clk); wr_data = 8'h05;
    check("burst_full_after_4", full, 1);
    @(negedge clk); wr_en = 1'b0;
    check("burst_drop_still_full", full, 1);
    repeat (27) @(negedge clk);
    check("popedge_full_before", full, 1);
    check("popedge_sw8_low", sw8, 0);
    wr_en = 1'b1; wr_data = 8'h06;
    @(negedge clk);
    wr_en = 1'b0;
    check("popedge_write_ignored", full, 0);
    check("popedge_sw8", sw8, 1);
    check("popedge_uinput", uinput, 8'h01);
    wr_en = 1'b1; wr_data = 8'h07;
    @(negedge clk);
    wr_en = 1'b0;
    check("late_write_accepted", full, 1);
    repeat (30) @(negedge clk);
    for (int i = 1; i < 5; i++) begin
      check("period_pre_sw8", sw8, 0);
      check("period_pre_uinput", uinput, seq[i-1]);
      @(negedge clk);
      check("period_sw8", sw8, 1);
      check("period_uinput", uinput, seq[i]);
      repeat (31) @(negedge clk);
    end
    @(negedge clk);
    check("burst_end_busy", busy, 0);
    check("burst_end_empty", empty, 1);
    check("burst_end_uinput", uinput, 8'h07);
    check("burst_end_result", result, CAP ? 32'h3C : 32'h0);
    check("burst_end_result_valid", result_valid, CAP);

    // Reset mid-PRESENT with two bytes queued
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h33;
    @(negedge clk); wr_data = 8'h44;
    @(negedge clk); wr_data = 8'h55;
    check("abort_uinput", uinput, 8'h33);
    @(negedge clk); wr_en = 1'b0;
    check("abort_queued", empty, 0);
    repeat (3) @(negedge clk);
    check("abort_sw8_high_5th", sw8, 1);
    rv_before = rv_count;
    #2 nreset = 1'b0;
    #1;
    check("abort_sw8_async", sw8, 0);
    check("abort_empty", empty, 1);
    check("abort_busy", busy, 0);
    check("abort_uinput_rst", uinput, 8'h00);
    @(negedge clk);
    nreset = 1'b1;
    seen_sw8 = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (sw8 !== 1'b0) seen_sw8 = 1'b1;
    end
    check("abort_no_transfer", seen_sw8, 0);
    check("abort_still_empty", empty, 1);
    check("abort_no_result_valid", rv_count - rv_before, 0);
    check("total_result_valid_pulses", rv_count, CAP ? 32'd7 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
